// File: rtl/k_switch_seq.sv
// Break-before-make sequencer for the 4-bit analog switch word.
// Opens departing switches, waits a dead time, then closes new ones and settles.
module k_switch_seq #(
    parameter int unsigned DEAD_CYCLES   = 50000,
    parameter int unsigned SETTLE_CYCLES = 500000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] K_req,
    output logic [3:0] Sw_out,
    output logic       Busy,
    output logic       Settled,
    output logic [7:0] Chg_cnt
);

    localparam int unsigned MAXC =
        (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DEAD_LD   = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cur_q, cur_d;
    logic [3:0]    tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    kprev_q;
    logic [3:0]    sw_q, sw_d;
    logic          busy_q, busy_d;
    logic          settled_q, settled_d;
    logic [7:0]    chg_q, chg_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            kprev_q   <= '0;
            sw_q      <= '0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
            chg_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            kprev_q   <= K_req;
            sw_q      <= sw_d;
            busy_q    <= busy_d;
            settled_q <= settled_d;
            chg_q     <= chg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        sw_d      = sw_q;
        busy_d    = busy_q;
        settled_d = settled_q;

        unique case (state_q)
            IDLE: begin
                sw_d      = cur_q;
                busy_d    = 1'b0;
                settled_d = 1'b1;
                if (K_req != cur_q) begin
                    tgt_d     = K_req;
                    busy_d    = 1'b1;
                    settled_d = 1'b0;
                    // Any switch that must open forces the dead-time phase
                    if ((cur_q & ~K_req) != 4'd0) begin
                        state_d = BREAK;
                        cnt_d   = DEAD_LD;
                        sw_d    = cur_q & K_req;
                    end else begin
                        state_d = MAKE;
                        cnt_d   = SETTLE_LD;
                        sw_d    = K_req;
                    end
                end
            end
            BREAK: begin
                if (cnt_q == '0) begin
                    state_d = MAKE;
                    cnt_d   = SETTLE_LD;
                    sw_d    = tgt_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    sw_d  = cur_q & tgt_q;
                end
            end
            MAKE: begin
                sw_d = tgt_q;
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    cur_d     = tgt_q;
                    busy_d    = 1'b0;
                    settled_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        chg_d = chg_q;
        if (busy_q && (K_req != kprev_q) && (chg_q != 8'hFF)) begin
            chg_d = chg_q + 8'd1;
        end
    end

    assign Sw_out  = sw_q;
    assign Busy    = busy_q;
    assign Settled = settled_q;
    assign Chg_cnt = chg_q;

endmodule

// File: tb/tb_k_switch_seq.sv
// Directed bench for k_switch_seq with DEAD_CYCLES=4, SETTLE_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_k_switch_seq;

    logic       Clk;
    logic       Reset;
    logic [3:0] K_req;
    logic [3:0] Sw_out;
    logic       Busy;
    logic       Settled;
    logic [7:0] Chg_cnt;

    int checks = 0;
    int errors = 0;

    k_switch_seq #(
        .DEAD_CYCLES  (4),
        .SETTLE_CYCLES(8)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .K_req  (K_req),
        .Sw_out (Sw_out),
        .Busy   (Busy),
        .Settled(Settled),
        .Chg_cnt(Chg_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sw,
                           input logic busy, input logic settled);
        chk({tag, " sw"}, {4'd0, Sw_out}, {4'd0, sw});
        chk({tag, " busy"}, {7'd0, Busy}, {7'd0, busy});
        chk({tag, " settled"}, {7'd0, Settled}, {7'd0, settled});
    endtask

    logic [7:0] prev_chg;

    initial begin
        Reset = 1'b1;
        K_req = 4'b0000;
        tick();
        tick();
        chk_out("reset", 4'b0000, 1'b0, 1'b0);
        chk("reset chg", Chg_cnt, 8'd0);

        // Idle with K_req = 0
        Reset = 1'b0;
        tick();
        chk_out("post-reset", 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("idle0", 4'b0000, 1'b0, 1'b1);
        end

        // 0000 -> 0101: closures only, no BREAK
        K_req = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("make0101", 4'b0101, 1'b1, 1'b0);
        end
        tick();
        chk_out("idle0101", 4'b0101, 1'b0, 1'b1);

        // 0101 -> 0110: BREAK 0100 x4, MAKE 0110 x8
        K_req = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("break0100", 4'b0100, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("make0110", 4'b0110, 1'b1, 1'b0);
            chk("bb4m overlap", {7'd0, Sw_out[1] & Sw_out[0]}, 8'd0);
        end
        tick();
        chk_out("idle0110", 4'b0110, 1'b0, 1'b1);

        // Back to cur=0000 via reset
        Reset = 1'b1;
        K_req = 4'b0000;
        tick();
        chk_out("rst2", 4'b0000, 1'b0, 1'b0);
        Reset = 1'b0;
        tick();
        chk_out("rst2 rel", 4'b0000, 1'b0, 1'b1);

        // 0011 requested, then 1000, 1100 while busy
        K_req = 4'b0011;
        tick();
        chk_out("m0011 a", 4'b0011, 1'b1, 1'b0);
        K_req = 4'b1000;
        tick();
        chk_out("m0011 b", 4'b0011, 1'b1, 1'b0);
        K_req = 4'b1100;
        tick();
        chk_out("m0011 c", 4'b0011, 1'b1, 1'b0);
        chk("chg after toggles", Chg_cnt, 8'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("m0011 d", 4'b0011, 1'b1, 1'b0);
        end
        tick();
        chk_out("idle0011", 4'b0011, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("break0000", 4'b0000, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("make1100", 4'b1100, 1'b1, 1'b0);
        end
        tick();
        chk_out("idle1100", 4'b1100, 1'b0, 1'b1);
        chk("chg final", Chg_cnt, 8'd2);

        // 1100 -> 1111, then 1111 -> 0001 with reset mid-BREAK
        K_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out("make1111", 4'b1111, 1'b1, 1'b0);
        end
        tick();
        chk_out("idle1111", 4'b1111, 1'b0, 1'b1);
        K_req = 4'b0001;
        tick();
        chk_out("break0001 1", 4'b0001, 1'b1, 1'b0);
        tick();
        chk_out("break0001 2", 4'b0001, 1'b1, 1'b0);
        Reset = 1'b1;
        K_req = 4'b0000;
        tick();
        chk_out("rst midbreak", 4'b0000, 1'b0, 1'b0);
        chk("rst midbreak chg", Chg_cnt, 8'd0);
        Reset = 1'b0;
        tick();
        chk_out("rst3 rel", 4'b0000, 1'b0, 1'b1);

        // Saturation: toggle every cycle while transitions keep Busy high
        prev_chg = Chg_cnt;
        for (int i = 0; i < 400; i++) begin
            K_req = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            tick();
            checks++;
            assert (Chg_cnt >= prev_chg) else begin
                errors++;
                $error("FAIL chg monotonic: observed %0d expected >= %0d",
                       Chg_cnt, prev_chg);
            end
            prev_chg = Chg_cnt;
        end
        chk("chg saturated", Chg_cnt, 8'd255);
        for (int i = 0; i < 20; i++) begin
            K_req = ~K_req;
            tick();
        end
        chk("chg no wrap", Chg_cnt, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
